// File: rtl/key_lock_pkg.sv
// rtl/key_lock_pkg.sv - shared key-lock types and defaults
//
// Purpose: state encoding and default sizing shared by the key loader and
//          the locked datapath blocks that consume its key.
// Ports:   none (package).
package key_lock_pkg;

  localparam int KEY_W_DEF    = 4;
  localparam int MAX_FAIL_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_DONE    = 3'd3,
    ST_LOCKOUT = 3'd4
  } key_state_t;

endpackage

// File: rtl/key_loader.sv
// rtl/key_loader.sv - serial key loader with parity check and lockout
//
// Purpose: shifts a KEY_W-bit key plus one even-parity bit (MSB first) in
//          from secure storage, releases the key only after the parity
//          check passes, and locks out permanently after MAX_FAIL
//          consecutive parity failures (only rst recovers).
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   start      - single-cycle load request (honoured in IDLE/DONE)
//   ser_valid  - ser_data carries a bit
//   ser_data   - serial key/parity bit
//   ser_ready  - a bit is accepted this cycle (SHIFT only)
//   key        - verified key, zero unless key_valid
//   key_valid  - key holds a verified key
//   busy       - load in progress (SHIFT or CHECK)
//   error      - one-cycle pulse during a failing CHECK
//   locked_out - permanent lockout reached
//   fail_cnt   - consecutive parity failure count, saturating
module key_loader
  import key_lock_pkg::*;
#(
  parameter int KEY_W    = KEY_W_DEF,
  parameter int MAX_FAIL = MAX_FAIL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ser_valid,
  input  logic             ser_data,
  output logic             ser_ready,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             busy,
  output logic             error,
  output logic             locked_out,
  output logic [1:0]       fail_cnt
);

  localparam int               CNT_W    = $clog2(KEY_W + 2);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_W);
  localparam logic [1:0]       FAIL_MAX = 2'(MAX_FAIL);

  key_state_t       state;
  logic [KEY_W:0]   frame;
  logic [CNT_W-1:0] bit_cnt;
  logic [KEY_W:0]   frame_next;
  logic [1:0]       fail_inc;

  // Frame register as it will look once the current serial bit is shifted in;
  // the parity bit ends up in bit 0, the key in the bits above it.
  assign frame_next = {frame[KEY_W-1:0], ser_data};
  assign fail_inc   = (fail_cnt >= FAIL_MAX) ? FAIL_MAX : fail_cnt + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      frame      <= '0;
      bit_cnt    <= '0;
      key        <= '0;
      key_valid  <= 1'b0;
      ser_ready  <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
      locked_out <= 1'b0;
      fail_cnt   <= 2'd0;
    end else begin
      error <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_SHIFT;
            bit_cnt   <= '0;
            key       <= '0;
            key_valid <= 1'b0;
            ser_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (ser_valid) begin
            frame   <= frame_next;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == LAST_BIT) begin
              // Parity verdict is registered here so error is high for
              // exactly the CHECK cycle.
              state     <= ST_CHECK;
              ser_ready <= 1'b0;
              error     <= ^frame_next;
            end
          end
        end
        ST_CHECK: begin
          busy <= 1'b0;
          if (error) begin
            fail_cnt <= fail_inc;
            if (fail_inc == FAIL_MAX) begin
              state      <= ST_LOCKOUT;
              locked_out <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            key       <= frame[KEY_W:1];
            key_valid <= 1'b1;
            fail_cnt  <= 2'd0;
            state     <= ST_DONE;
          end
        end
        ST_LOCKOUT: begin
          state <= ST_LOCKOUT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_loader.sv
// tb/tb_key_loader.sv - randomized and directed bench for key_loader
module tb_key_loader;

  localparam int KW = 4;
  localparam int MF = 3;

  localparam int M_IDLE  = 0;
  localparam int M_SHIFT = 1;
  localparam int M_CHECK = 2;
  localparam int M_DONE  = 3;
  localparam int M_LOCK  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          ser_valid = 1'b0;
  logic          ser_data = 1'b0;
  logic          ser_ready;
  logic [KW-1:0] key;
  logic          key_valid;
  logic          busy;
  logic          error;
  logic          locked_out;
  logic [1:0]    fail_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a mode number, a queue of received frame bits,
  // the released key value and the failure count.
  int m_mode = M_IDLE;
  bit m_q[$];
  int m_key = 0;
  bit m_kv = 1'b0;
  bit m_err = 1'b0;
  int m_fail = 0;

  key_loader #(.KEY_W(KW), .MAX_FAIL(MF)) dut (
    .clk(clk), .rst(rst), .start(start), .ser_valid(ser_valid),
    .ser_data(ser_data), .ser_ready(ser_ready), .key(key),
    .key_valid(key_valid), .busy(busy), .error(error),
    .locked_out(locked_out), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit s, input bit v, input bit d);
    int par;
    if (r) begin
      m_mode = M_IDLE; m_q.delete(); m_key = 0; m_kv = 0; m_err = 0; m_fail = 0;
      return;
    end
    case (m_mode)
      M_IDLE, M_DONE: if (s) begin
        m_mode = M_SHIFT; m_q.delete(); m_key = 0; m_kv = 0;
      end
      M_SHIFT: if (v) begin
        m_q.push_back(d);
        if (m_q.size() == KW + 1) begin
          par = 0;
          foreach (m_q[i]) par = par ^ int'(m_q[i]);
          m_err = (par != 0);
          m_mode = M_CHECK;
        end
      end
      M_CHECK: begin
        if (m_err) begin
          m_fail = (m_fail + 1 > MF) ? MF : m_fail + 1;
          m_mode = (m_fail == MF) ? M_LOCK : M_IDLE;
        end else begin
          m_key = 0;
          for (int i = 0; i < KW; i++) m_key = m_key * 2 + int'(m_q[i]);
          m_kv = 1; m_fail = 0; m_mode = M_DONE;
        end
        m_err = 0;
      end
      default: ;
    endcase
  endtask

  // Advance one clock: capture the inputs the DUT samples on the coming edge,
  // then at the falling edge step the model and compare every output.
  task automatic step();
    bit r, s, v, d;
    r = rst; s = start; v = ser_valid; d = ser_data;
    @(negedge clk);
    model_update(r, s, v, d);
    check("cyc ser_ready", 32'(ser_ready), 32'(m_mode == M_SHIFT));
    check("cyc busy", 32'(busy), 32'(m_mode == M_SHIFT || m_mode == M_CHECK));
    check("cyc locked_out", 32'(locked_out), 32'(m_mode == M_LOCK));
    check("cyc key", 32'(key), 32'(m_key));
    check("cyc key_valid", 32'(key_valid), 32'(m_kv));
    check("cyc error", 32'(error), 32'(m_mode == M_CHECK && m_err));
    check("cyc fail_cnt", 32'(fail_cnt), 32'(m_fail));
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input bit b, input int gap);
    repeat (gap) step();
    ser_valid = 1'b1;
    ser_data  = b;
    step();
    ser_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [KW:0] bits, input int gap);
    for (int i = KW; i >= 0; i--) send(bits[i], gap);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst key", 32'(key), 32'h0);
    check("rst key_valid", 32'(key_valid), 32'h0);
    check("rst ser_ready", 32'(ser_ready), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst error", 32'(error), 32'h0);
    check("rst locked_out", 32'(locked_out), 32'h0);
    check("rst fail_cnt", 32'(fail_cnt), 32'h0);
    rst = 1'b0;
    step();

    // Good frame 1,1,0,1,1
    do_start();
    check("good shift ready", 32'(ser_ready), 32'h1);
    check("good shift busy", 32'(busy), 32'h1);
    send_frame(5'b11011, 0);
    check("good check busy", 32'(busy), 32'h1);
    check("good check error", 32'(error), 32'h0);
    check("good check ready", 32'(ser_ready), 32'h0);
    step();
    check("good key", 32'(key), 32'hd);
    check("good key_valid", 32'(key_valid), 32'h1);
    check("good fail_cnt", 32'(fail_cnt), 32'h0);
    check("good busy", 32'(busy), 32'h0);
    repeat (3) step();
    check("done hold key", 32'(key), 32'hd);

    // Reload from DONE with 0,1,1,0,0
    do_start();
    check("reload key_valid drop", 32'(key_valid), 32'h0);
    check("reload key zero", 32'(key), 32'h0);
    send_frame(5'b01100, 0);
    step();
    check("reload key", 32'(key), 32'h6);
    check("reload key_valid", 32'(key_valid), 32'h1);

    // Bad frame 1,1,0,1,0
    do_start();
    send_frame(5'b11010, 0);
    check("bad error pulse", 32'(error), 32'h1);
    step();
    check("bad error end", 32'(error), 32'h0);
    check("bad fail_cnt", 32'(fail_cnt), 32'h1);
    check("bad key", 32'(key), 32'h0);
    check("bad key_valid", 32'(key_valid), 32'h0);
    check("bad idle ready", 32'(ser_ready), 32'h0);
    check("bad idle busy", 32'(busy), 32'h0);

    // Three consecutive bad frames -> lockout
    pulse_rst();
    for (int k = 0; k < 3; k++) begin
      do_start();
      send_frame(5'b11010, 0);
      step();
    end
    check("lock locked_out", 32'(locked_out), 32'h1);
    check("lock fail_cnt", 32'(fail_cnt), 32'h3);
    do_start();
    step();
    check("lock start ignored ready", 32'(ser_ready), 32'h0);
    check("lock start ignored busy", 32'(busy), 32'h0);
    send_frame(5'b11011, 0);
    step();
    check("lock no key_valid", 32'(key_valid), 32'h0);
    check("lock no key", 32'(key), 32'h0);
    check("lock still locked", 32'(locked_out), 32'h1);
    pulse_rst();
    check("unlock locked_out", 32'(locked_out), 32'h0);
    check("unlock fail_cnt", 32'(fail_cnt), 32'h0);

    // Good frame with 3-cycle ser_valid gaps
    do_start();
    send_frame(5'b11011, 3);
    step();
    check("gap key", 32'(key), 32'hd);
    check("gap key_valid", 32'(key_valid), 32'h1);
    check("gap fail_cnt", 32'(fail_cnt), 32'h0);

    // Reset after two accepted bits, then a full good load
    do_start();
    send(1'b1, 0);
    send(1'b1, 0);
    pulse_rst();
    check("midrst key", 32'(key), 32'h0);
    check("midrst key_valid", 32'(key_valid), 32'h0);
    check("midrst busy", 32'(busy), 32'h0);
    check("midrst ready", 32'(ser_ready), 32'h0);
    do_start();
    send_frame(5'b11011, 0);
    step();
    check("midrst reload key", 32'(key), 32'hd);
    check("midrst reload key_valid", 32'(key_valid), 32'h1);

    // Randomized traffic, all checked against the model every cycle
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      start     = ($urandom_range(0, 7) == 0);
      ser_valid = $urandom_range(0, 1) == 1;
      ser_data  = $urandom_range(0, 1) == 1;
      step();
    end
    rst = 1'b0; start = 1'b0; ser_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
